alu_pipe: RTL

Parametrised successor to the CPU's single-cycle ALU. It accepts one operation per valid/ready handshake and produces a registered result with a one-cycle `out_valid` pulse. It holds a reset-cleared flag register that carries across operations (ADC/SBC/RLC/RRC chains). An optional iterative multiplier gives a double-width product. Branch conditions are evaluated from the registered flags, and the block sits between the register file read ports and the data bus write-back mux.

---
 rtl/alu_pipe_pkg.sv | 68 ++++++
 rtl/alu_mul_iter.sv | 51 +++++
 rtl/alu_pipe.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcodes, flag indices, FSM state type and branch evaluation for alu_pipe
package alu_pipe_pkg;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // two-operand group (single = 0)
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    // single-operand group (single = 1)
    localparam logic [3:0] OP_NEG = 4'd0;
    localparam logic [3:0] OP_COM = 4'd1;
    localparam logic [3:0] OP_LSL = 4'd2;
    localparam logic [3:0] OP_LSR = 4'd3;
    localparam logic [3:0] OP_ROL = 4'd4;
    localparam logic [3:0] OP_ROR = 4'd5;
    localparam logic [3:0] OP_RLC = 4'd6;
    localparam logic [3:0] OP_RRC = 4'd7;

    // branch codes share the operator field
    localparam logic [3:0] OP_BREQ = 4'd0;
    localparam logic [3:0] OP_BRNE = 4'd1;
    localparam logic [3:0] OP_BRLT = 4'd2;
    localparam logic [3:0] OP_BRGE = 4'd3;
    localparam logic [3:0] OP_BRC  = 4'd4;
    localparam logic [3:0] OP_BRLO = 4'd5;
    localparam logic [3:0] OP_BRNC = 4'd6;
    localparam logic [3:0] OP_BRSH = 4'd7;
    localparam logic [3:0] OP_BRO  = 4'd8;
    localparam logic [3:0] OP_BRNO = 4'd9;
    localparam logic [3:0] OP_BRN  = 4'd10;
    localparam logic [3:0] OP_BRNN = 4'd11;
    localparam logic [3:0] OP_RJMP = 4'd12;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } alu_state_t;

    function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] f);
        case (op)
            OP_BREQ: return f[FLAG_Z];
            OP_BRNE: return ~f[FLAG_Z];
            OP_BRLT: return f[FLAG_N] ^ f[FLAG_V];
            OP_BRGE: return ~(f[FLAG_N] ^ f[FLAG_V]);
            OP_BRC,  OP_BRLO: return f[FLAG_C];
            OP_BRNC, OP_BRSH: return ~f[FLAG_C];
            OP_BRO:  return f[FLAG_V];
            OP_BRNO: return ~f[FLAG_V];
            OP_BRN:  return f[FLAG_N];
            OP_BRNN: return ~f[FLAG_N];
            OP_RJMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - radix-2 shift-add unsigned multiplier, one step per cycle, WIDTH steps
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // o_product is the value after the current step, so the final step's result is usable at the done edge
    assign o_product = {w_sum[WIDTH:1], w_sum[0], r_lo[WIDTH-1:1]};
    assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= i_a;
            r_hi    <= '0;
            r_lo    <= i_b;
        end else if (r_busy) begin
            r_hi  <= w_sum[WIDTH:1];
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with carried flags and branch check; ALU_MUL_EN adds iterative MUL
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_single,
    input  logic [3:0]       i_operator,
    input  logic [WIDTH-1:0] i_value1,
    input  logic [WIDTH-1:0] i_value2,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_bus_out,
    output logic [WIDTH-1:0] o_bus_out_hi,
    output logic [3:0]       o_alu_flags,
    output logic             o_check_branch
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_bus;
    logic [3:0]       r_flags;
    logic             r_valid;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c, w_v, w_defined, w_wr_bus, w_accept;
    logic [3:0]       w_flags;
    logic             w_cin;

    assign w_cin          = r_flags[FLAG_C];
    assign w_accept       = i_in_valid && o_in_ready;
    assign o_bus_out      = r_bus;
    assign o_alu_flags    = r_flags;
    assign o_out_valid    = r_valid;
    assign o_check_branch = branch_taken(i_operator, r_flags);

    always_comb begin
        w_res     = '0;
        w_sum     = '0;
        w_c       = w_cin;
        w_v       = 1'b0;
        w_defined = 1'b1;
        w_wr_bus  = 1'b1;
        if (!i_single) begin
            case (i_operator)
                OP_ADD, OP_ADC: begin
                    w_sum = {1'b0, i_value1} + {1'b0, i_value2}
                          + ((i_operator == OP_ADC) ? {{WIDTH{1'b0}}, w_cin} : {(WIDTH+1){1'b0}});
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (i_value1[MSB] == i_value2[MSB]) && (w_res[MSB] != i_value1[MSB]);
                end
                OP_SUB, OP_SBC, OP_CMP: begin
                    // bit WIDTH of the extended difference is the borrow
                    w_sum = {1'b0, i_value1} - {1'b0, i_value2}
                          - ((i_operator == OP_SBC) ? {{WIDTH{1'b0}}, w_cin} : {(WIDTH+1){1'b0}});
                    w_res    = w_sum[WIDTH-1:0];
                    w_c      = w_sum[WIDTH];
                    w_v      = (i_value1[MSB] != i_value2[MSB]) && (w_res[MSB] != i_value1[MSB]);
                    w_wr_bus = (i_operator != OP_CMP);
                end
                OP_AND:  w_res = i_value1 & i_value2;
                OP_OR:   w_res = i_value1 | i_value2;
                OP_XOR:  w_res = i_value1 ^ i_value2;
                OP_MOV:  w_res = i_value2;
                default: w_defined = 1'b0;
            endcase
        end else begin
            case (i_operator)
                OP_NEG: begin
                    w_res = '0 - i_value1;
                    w_c   = |i_value1;
                    w_v   = (i_value1 == MSB_ONLY);
                end
                OP_COM:  w_res = ~i_value1;
                OP_LSL:  begin w_res = {i_value1[MSB-1:0], 1'b0};        w_c = i_value1[MSB]; end
                OP_LSR:  begin w_res = {1'b0, i_value1[MSB:1]};          w_c = i_value1[0];   end
                OP_ROL:  begin w_res = {i_value1[MSB-1:0], i_value1[MSB]}; w_c = i_value1[MSB]; end
                OP_ROR:  begin w_res = {i_value1[0], i_value1[MSB:1]};   w_c = i_value1[0];   end
                OP_RLC:  begin w_res = {i_value1[MSB-1:0], w_cin};       w_c = i_value1[MSB]; end
                OP_RRC:  begin w_res = {w_cin, i_value1[MSB:1]};         w_c = i_value1[0];   end
                default: w_defined = 1'b0;
            endcase
            if (w_defined && i_operator != OP_NEG && i_operator != OP_COM) begin
                w_v = w_res[MSB] ^ i_value1[MSB];
            end
        end
        w_flags = w_defined ? {w_c, w_v, ~|w_res, w_res[MSB]} : r_flags;
    end

`ifdef ALU_MUL_EN
    alu_state_t           r_state;
    logic [WIDTH-1:0]     r_bus_hi;
    logic                 w_is_mul;
    logic                 w_mul_done;
    logic                 w_hi_nz;
    logic [2*WIDTH-1:0]   w_product;

    assign w_is_mul     = !i_single && (i_operator == OP_MUL);
    assign w_hi_nz      = |w_product[2*WIDTH-1:WIDTH];
    assign o_in_ready   = (r_state == ST_IDLE);
    assign o_bus_out_hi = r_bus_hi;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_a       (i_value1),
        .i_b       (i_value2),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_bus    <= '0;
            r_bus_hi <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_valid  <= 1'b1;
                            r_bus_hi <= '0;
                            r_flags  <= w_flags;
                            if (w_wr_bus) begin
                                r_bus <= w_res;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_state  <= ST_IDLE;
                        r_valid  <= 1'b1;
                        r_bus    <= w_product[WIDTH-1:0];
                        r_bus_hi <= w_product[2*WIDTH-1:WIDTH];
                        r_flags  <= {w_hi_nz, w_hi_nz, ~|w_product[WIDTH-1:0], w_product[WIDTH-1]};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_in_ready   = 1'b1;
    assign o_bus_out_hi = '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus   <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_flags <= w_flags;
                if (w_wr_bus) begin
                    r_bus <= w_res;
                end
            end
        end
    end
`endif

endmodule
